// File: rtl/rom_loader.sv
// Program ROM with a byte-stream loader. Each word arrives as two bytes, high
// byte first. The CPU is held in reset while a load is in progress.
module rom_loader #(
  parameter int ADDR_W = 15  // 1..15 so that DEPTH fits in the 16-bit ld_count
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pcaddr,
  output logic [15:0] instruction,
  input  logic        ld_start,
  input  logic [15:0] ld_len,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        cpu_reset,
  output logic        ld_busy,
  output logic        ld_done,
  output logic [15:0] ld_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_HI,
    S_LOAD_LO,
    S_FLUSH
  } state_t;

  state_t            r_state;
  logic              r_cpu_reset;
  logic              r_done;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_hold;
  logic [15:0]       r_rom [DEPTH];

  logic [CNT_W-1:0]  w_len_clamp;
  logic [CNT_W-1:0]  w_count_inc;
  logic              w_we;
  logic              w_rom_visible;
  logic              w_unused_pc;

  // A request longer than the ROM is clamped, so the write address never wraps.
  assign w_len_clamp = ({1'b0, ld_len} > 17'(DEPTH)) ? CNT_W'(DEPTH) : CNT_W'(ld_len);
  assign w_count_inc = r_count + CNT_W'(1);

  assign ld_ready = (r_state == S_LOAD_HI) || (r_state == S_LOAD_LO);
  assign ld_busy  = (r_state != S_IDLE);
  assign w_we     = (r_state == S_LOAD_LO) && ld_valid;

  assign cpu_reset = r_cpu_reset;
  assign ld_done   = r_done;
  assign ld_count  = 16'(r_count);

  assign w_unused_pc = ^pcaddr[15:ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_len       <= '0;
      r_count     <= '0;
      r_addr      <= '0;
      r_hold      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cpu_reset <= 1'b0;
          if (ld_start) begin
            r_len       <= w_len_clamp;
            r_addr      <= '0;
            r_count     <= '0;
            r_cpu_reset <= 1'b1;
            if (w_len_clamp == '0) begin
              r_state <= S_FLUSH;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_LOAD_HI;
            end
          end
        end
        S_LOAD_HI: begin
          if (ld_valid) begin
            r_hold  <= ld_data;
            r_state <= S_LOAD_LO;
          end
        end
        S_LOAD_LO: begin
          if (ld_valid) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_count != CNT_W'(DEPTH)) r_count <= w_count_inc;
            if (w_count_inc == r_len) begin
              r_state <= S_FLUSH;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_LOAD_HI;
            end
          end
        end
        S_FLUSH: begin
          r_state     <= S_IDLE;
          r_cpu_reset <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the ROM array has no reset on purpose -- a loaded program must survive a reset.
  always_ff @(posedge clk) begin
    if (w_we) r_rom[r_addr] <= {r_hold, ld_data};
  end

  assign w_rom_visible = !reset && ((r_state == S_IDLE) || (r_state == S_FLUSH));
  assign instruction   = w_rom_visible ? r_rom[pcaddr[ADDR_W-1:0]] : 16'h0000;

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader: reset, normal and stalled loads,
// zero-length load, ignored restart, mid-load reset and the length clamp.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pcaddr;
  logic [15:0] instruction;
  logic        ld_start;
  logic [15:0] ld_len;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        cpu_reset;
  logic        ld_busy;
  logic        ld_done;
  logic [15:0] ld_count;

  int total = 0;
  int bad   = 0;

  rom_loader #(.ADDR_W(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .pcaddr      (pcaddr),
    .instruction (instruction),
    .ld_start    (ld_start),
    .ld_len      (ld_len),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .cpu_reset   (cpu_reset),
    .ld_busy     (ld_busy),
    .ld_done     (ld_done),
    .ld_count    (ld_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_rom(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    pcaddr = addr;
    #1;
    check(tag, instruction, exp);
  endtask

  initial begin
    logic [7:0]  bytes_a [4];
    logic [15:0] w;

    reset = 1'b1; pcaddr = 16'h0000; ld_start = 1'b0; ld_len = 16'h0000;
    ld_valid = 1'b0; ld_data = 8'h00;

    // Reset behaviour
    #2;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_ready", ld_ready, 0);
    check("rst_busy", ld_busy, 0);
    check("rst_done", ld_done, 0);
    check("rst_count", ld_count, 0);
    check("rst_instr", instruction, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rel_cpu_reset_before_edge", cpu_reset, 1);
    tick();
    check("rel_cpu_reset_after_edge", cpu_reset, 0);
    check("rel_count", ld_count, 0);
    check("rel_ready", ld_ready, 0);

    // Basic load of two words; a valid byte in the start cycle must be ignored
    ld_start = 1'b1; ld_len = 16'd2; ld_valid = 1'b1; ld_data = 8'hFF;
    tick();
    ld_start = 1'b0;
    check("ld2_ready_hi", ld_ready, 1);
    check("ld2_cpu_reset", cpu_reset, 1);
    check("ld2_busy", ld_busy, 1);
    bytes_a = '{8'h30, 8'h39, 8'hEC, 8'h10};
    for (int i = 0; i < 4; i++) begin
      ld_data = bytes_a[i];
      tick();
      if (i == 1) check("ld2_count_after_w0", ld_count, 1);
      if (i < 3)  check("ld2_no_early_done", ld_done, 0);
    end
    ld_valid = 1'b0;
    check("ld2_done", ld_done, 1);
    check("ld2_count", ld_count, 2);
    check("ld2_flush_cpu_reset", cpu_reset, 1);
    check("ld2_flush_ready", ld_ready, 0);
    read_rom(16'h0001, 16'hEC10, "ld2_flush_rom1");
    tick();
    check("ld2_done_one_cycle", ld_done, 0);
    check("ld2_cpu_reset_low", cpu_reset, 0);
    check("ld2_idle_busy", ld_busy, 0);
    read_rom(16'h0000, 16'h3039, "ld2_rom0");
    read_rom(16'h8001, 16'hEC10, "ld2_pc_upper_ignored");

    // Load with ld_valid low on alternate cycles
    ld_start = 1'b1; ld_len = 16'd2;
    tick();
    ld_start = 1'b0;
    bytes_a = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b0;
      tick();
      check($sformatf("alt_ready_stall%0d", i), ld_ready, 1);
      check($sformatf("alt_count_stall%0d", i), ld_count, 32'(i / 2));
      ld_valid = 1'b1; ld_data = bytes_a[i];
      tick();
      check($sformatf("alt_count_byte%0d", i), ld_count, 32'((i + 1) / 2));
      if (i < 3) check($sformatf("alt_ready_byte%0d", i), ld_ready, 1);
    end
    ld_valid = 1'b0;
    check("alt_done", ld_done, 1);
    tick();
    read_rom(16'h0000, 16'h1234, "alt_rom0");
    read_rom(16'h0001, 16'h5678, "alt_rom1");

    // Zero-length load goes straight to FLUSH
    ld_start = 1'b1; ld_len = 16'd0; ld_valid = 1'b1; ld_data = 8'hAA;
    tick();
    ld_start = 1'b0;
    check("len0_done", ld_done, 1);
    check("len0_ready", ld_ready, 0);
    check("len0_busy", ld_busy, 1);
    check("len0_cpu_reset", cpu_reset, 1);
    check("len0_count", ld_count, 0);
    tick();
    ld_valid = 1'b0;
    check("len0_done_clear", ld_done, 0);
    check("len0_ready_idle", ld_ready, 0);
    check("len0_cpu_reset_low", cpu_reset, 0);
    read_rom(16'h0000, 16'h1234, "len0_rom0_kept");

    // ld_start during a load is ignored and the length is not reloaded
    ld_start = 1'b1; ld_len = 16'd2;
    tick();
    ld_len = 16'd1; ld_valid = 1'b0;
    tick();
    ld_start = 1'b0;
    check("restart_ready", ld_ready, 1);
    check("restart_count", ld_count, 0);
    bytes_a = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_data = bytes_a[i];
      tick();
      if (i == 1) check("restart_no_done_after_w0", ld_done, 0);
      if (i == 1) check("restart_ready_after_w0", ld_ready, 1);
    end
    ld_valid = 1'b0;
    check("restart_done", ld_done, 1);
    check("restart_count_final", ld_count, 2);
    read_rom(16'h0000, 16'hDEAD, "restart_rom0");
    read_rom(16'h0001, 16'hBEEF, "restart_rom1");
    tick();

    // Reset in the middle of a 4-word load, after three bytes
    ld_start = 1'b1; ld_len = 16'd4;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1;
    bytes_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 3; i++) begin
      ld_data = bytes_a[i];
      tick();
    end
    check("abort_count_before", ld_count, 1);
    ld_data = bytes_a[3];
    reset = 1'b1;
    #1;
    check("abort_busy", ld_busy, 0);
    check("abort_ready", ld_ready, 0);
    check("abort_cpu_reset", cpu_reset, 1);
    check("abort_count", ld_count, 0);
    check("abort_instr", instruction, 0);
    tick();
    check("abort_done_in_reset", ld_done, 0);
    reset = 1'b0; ld_valid = 1'b0;
    tick();
    check("abort_done_after", ld_done, 0);
    check("abort_cpu_reset_low", cpu_reset, 0);
    check("abort_idle", ld_busy, 0);
    read_rom(16'h0000, 16'h1122, "abort_rom0_written");
    read_rom(16'h0001, 16'hBEEF, "abort_rom1_unchanged");

    // Over-long request is clamped to the 32768-word ROM
    ld_start = 1'b1; ld_len = 16'd40000;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1;
    for (int i = 0; i < 32768; i++) begin
      if (i == 16384) check("clamp_count_mid", ld_count, 16384);
      w = 16'(i) ^ 16'h0F0F;
      ld_data = w[15:8];
      tick();
      ld_data = w[7:0];
      tick();
    end
    check("clamp_done", ld_done, 1);
    check("clamp_count", ld_count, 32768);
    check("clamp_ready", ld_ready, 0);
    read_rom(16'h0000, 16'h0F0F, "clamp_rom_first");
    read_rom(16'h1234, 16'h1D3B, "clamp_rom_mid");
    read_rom(16'h7FFF, 16'h70F0, "clamp_rom_last");
    tick();
    ld_valid = 1'b0;
    check("clamp_idle", ld_busy, 0);
    check("clamp_count_hold", ld_count, 32768);
    check("clamp_cpu_reset_low", cpu_reset, 0);
    read_rom(16'h0000, 16'h0F0F, "clamp_rom0_not_overwritten");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ADDR_W, default 15, ROM word-address width; DEPTH = 2^ADDR_W words of 16 bits.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pcaddr  input  16  program counter from the CPU; bits [ADDR_W-1:0] index the ROM, upper bits ignored.
REQ-005 instruction  output  16  instruction word to the CPU.
REQ-006 ld_start  input  1  one-cycle request to begin a program load.
REQ-007 ld_len  input  16  number of 16-bit words to load; sampled only when ld_start is accepted.
REQ-008 ld_valid  input  1  ld_data holds a valid byte.
REQ-009 ld_data  input  8  program byte stream, high byte of each word first.
REQ-010 ld_ready  output  1  loader accepts a byte this cycle.
REQ-011 cpu_reset  output  1  reset to the CPU, held high while loading.
REQ-012 ld_busy  output  1  load in progress.
REQ-013 ld_done  output  1  one-cycle load-complete pulse.
REQ-014 ld_count  output  16  words written in the current or last load.

Function
REQ-015 FSM states SHALL be IDLE, LOAD_HI, LOAD_LO, FLUSH; byte handshake = ld_valid && ld_ready.
REQ-016 ld_ready SHALL be 1 only in LOAD_HI and LOAD_LO (combinational from state); ld_busy SHALL be 1 in LOAD_HI, LOAD_LO, FLUSH.
REQ-017 IDLE + ld_start: capture len = min(ld_len, DEPTH), clear write address and ld_count, set cpu_reset=1; go to FLUSH if len==0, else LOAD_HI.
REQ-018 ld_start outside IDLE SHALL be ignored; ld_valid in IDLE SHALL NOT consume a byte, including in the ld_start cycle.
REQ-019 LOAD_HI + handshake: store byte in a hold register, go to LOAD_LO; no handshake: stay.
REQ-020 LOAD_LO + handshake: write {hold, ld_data} to rom[addr], addr++, ld_count++; go to FLUSH if ld_count+1 == len, else LOAD_HI.
REQ-021 FLUSH SHALL last exactly one cycle with ld_done=1 and cpu_reset=1, then go to IDLE and clear cpu_reset on that edge.
REQ-022 cpu_reset SHALL be registered; it is 0 in IDLE after the first clock edge following reset release.
REQ-023 instruction SHALL be rom[pcaddr[ADDR_W-1:0]], combinational read, when state is IDLE or FLUSH and reset is low; otherwise 16'h0000.
REQ-024 Write address SHALL never exceed DEPTH-1, which the len clamp guarantees; ld_count saturates at DEPTH.
REQ-025 ROM contents SHALL NOT be cleared by reset; words written before a reset are retained.

Reset
REQ-026 While reset is high: state=IDLE, cpu_reset=1, ld_ready=0, ld_busy=0, ld_done=0, ld_count=0, hold=0, instruction=16'h0000.
REQ-027 Reset asserted mid-load SHALL abort immediately: discard the hold byte, keep completed words, and return to IDLE with no ld_done pulse.
REQ-028 After reset release, the first clock edge in IDLE SHALL drive cpu_reset to 0.

Verification
REQ-029 Reset and release -> cpu_reset=1 during reset and 0 after the first edge; ld_count=0; ld_ready=0.
REQ-030 ld_start with ld_len=2, bytes 30,39,EC,10 on consecutive cycles -> rom[0]=3039, rom[1]=EC10, ld_count=2, ld_done high one cycle after the last byte edge, cpu_reset low one cycle later; pcaddr=1 -> instruction=EC10.
REQ-031 Same load with ld_valid low on alternate cycles -> identical ROM contents; ld_count increments only on LOAD_LO handshakes; ld_ready stays 1 throughout LOAD states.
REQ-032 ld_start with ld_len=0 -> FLUSH on the next edge, one ld_done pulse, ROM unchanged, ld_ready never 1.
REQ-033 Load ld_len=4, reset asserted after 3 bytes -> rom[0] written, rom[1] unchanged, ld_count=0, ld_done never pulses, state IDLE.
REQ-034 ld_start pulsed during LOAD_HI -> ignored with len unchanged; ld_len=40000 -> clamped to 32768 and stops after 32768 words with ld_count=32768.
